// File: rtl/ntt_pkg.sv
// Shared types and modular-arithmetic helpers for the radix-2 NTT engine.
package ntt_pkg;

  typedef enum logic [2:0] {IDLE, TWID, LOAD, COMP, SCALE, OUT} state_t;

  function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] q);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[31:0];
  endfunction

  function automatic logic [31:0] mod_sub(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] q);
    return (a >= b) ? (a - b) : (a + q - b);
  endfunction

  function automatic logic [31:0] mod_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] q);
    logic [63:0] p;
    p = ({32'd0, a} * {32'd0, b}) % {32'd0, q};
    return p[31:0];
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] k, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < bits) r[bits-1-i] = k[i];
    return r;
  endfunction

endpackage

// File: rtl/ntt_butterfly.sv
// Combinational modular butterfly: (u + tw*v, u - tw*v) mod Q.
module ntt_butterfly
  import ntt_pkg::*;
#(
  parameter int W = 7,
  parameter int Q = 97
) (
  input  logic [W-1:0] u_i,
  input  logic [W-1:0] v_i,
  input  logic [W-1:0] tw_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] diff_o
);

  logic [31:0] t;

  assign t      = mod_mul(32'(v_i), 32'(tw_i), 32'(Q));
  assign sum_o  = W'(mod_add(32'(u_i), t, 32'(Q)));
  assign diff_o = W'(mod_sub(32'(u_i), t, 32'(Q)));

endmodule

// File: rtl/ntt_engine.sv
// Streaming in-place radix-2 DIT NTT (forward/inverse) with run-time twiddle generation.
module ntt_engine
  import ntt_pkg::*;
#(
  parameter int LOG_N     = 4,
  parameter int W         = 7,
  parameter int Q         = 97,
  parameter int OMEGA     = 27,
  parameter int OMEGA_INV = 18,
  parameter int N_INV     = 91
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         inverse,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  localparam int N = 1 << LOG_N;
  localparam int H = N / 2;
  localparam logic [LOG_N-1:0] CNT_H    = LOG_N'(H - 1);
  localparam logic [LOG_N-1:0] CNT_N    = LOG_N'(N - 1);
  localparam logic [3:0]       STG_LAST = 4'(LOG_N - 1);

  state_t             state_q, state_d;
  logic [LOG_N-1:0]   cnt_q, cnt_d;
  logic [3:0]         stg_q, stg_d;
  logic               inv_q, inv_d;
  logic               done_q, done_d;

  logic [W-1:0]       data_q [N];
  logic [W-1:0]       tw_q   [H];

  logic [LOG_N-2:0]   bidx, mask, low, twidx, twprev;
  logic [LOG_N-1:0]   top, bot, ldidx;
  logic [W-1:0]       bf_u, bf_v, bf_tw, bf_sum, bf_diff;

  // Butterfly addressing: top=(b/m)*2m + b%m, bot=top+m, twiddle stride N/(2m)
  assign bidx   = cnt_q[LOG_N-2:0];
  assign mask   = (LOG_N-1)'((32'd1 << stg_q) - 32'd1);
  assign low    = bidx & mask;
  assign twidx  = low << (STG_LAST - stg_q);
  assign top    = {bidx & ~mask, 1'b0} | {1'b0, low};
  assign bot    = top | LOG_N'(32'd1 << stg_q);
  assign twprev = bidx - (LOG_N-1)'(1);
  assign ldidx  = LOG_N'(bitrev(32'(cnt_q), LOG_N));

  ntt_butterfly #(.W(W), .Q(Q)) u_bf (
    .u_i   (bf_u),
    .v_i   (bf_v),
    .tw_i  (bf_tw),
    .sum_o (bf_sum),
    .diff_o(bf_diff)
  );

  // One shared multiplier: twiddle recurrence, butterflies, and N^-1 scaling
  always_comb begin
    bf_u  = '0;
    bf_v  = tw_q[twprev];
    bf_tw = inv_q ? W'(OMEGA_INV) : W'(OMEGA);
    case (state_q)
      COMP: begin
        bf_u  = data_q[top];
        bf_v  = data_q[bot];
        bf_tw = tw_q[twidx];
      end
      SCALE: begin
        bf_v  = data_q[cnt_q];
        bf_tw = W'(N_INV);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stg_q   <= '0;
      inv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    inv_d   = inv_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        inv_d   = inverse;
        cnt_d   = '0;
        state_d = TWID;
      end
      TWID: if (cnt_q == CNT_H) begin
        cnt_d   = '0;
        state_d = LOAD;
      end else cnt_d = cnt_q + 1'b1;
      LOAD: if (in_valid) begin
        if (cnt_q == CNT_N) begin
          cnt_d   = '0;
          stg_d   = '0;
          state_d = COMP;
        end else cnt_d = cnt_q + 1'b1;
      end
      COMP: if (cnt_q == CNT_H) begin
        cnt_d = '0;
        if (stg_q == STG_LAST) state_d = inv_q ? SCALE : OUT;
        else stg_d = stg_q + 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      SCALE: if (cnt_q == CNT_N) begin
        cnt_d   = '0;
        state_d = OUT;
      end else cnt_d = cnt_q + 1'b1;
      OUT: if (out_ready) begin
        if (cnt_q == CNT_N) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage is not reset: every entry is rewritten before it is read in a job
  always_ff @(posedge clk) begin
    case (state_q)
      TWID:  tw_q[bidx] <= (cnt_q == '0) ? W'(1) : bf_sum;
      LOAD:  if (in_valid) data_q[ldidx] <= in_data;
      COMP: begin
        data_q[top] <= bf_sum;
        data_q[bot] <= bf_diff;
      end
      SCALE: data_q[cnt_q] <= bf_sum;
      default: ;
    endcase
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_valid ? data_q[cnt_q] : '0;
  assign out_last  = out_valid && (cnt_q == CNT_N);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_ntt_engine.sv
// Directed bench for ntt_engine: default 16-point instance plus an 8-point mod-17 instance.
`timescale 1ns/1ps
module tb_ntt_engine;

  logic       clk = 1'b0;
  logic       rst_n, start_a, start_b, inverse, in_valid, out_ready;
  logic [6:0] in_data;
  logic       a_in_ready, a_out_valid, a_out_last, a_busy, a_done;
  logic [6:0] a_out_data;
  logic       b_in_ready, b_out_valid, b_out_last, b_busy, b_done;
  logic [4:0] b_out_data;

  int nc = 0, nf = 0;
  int vec[16], res[16], ramp_out[16];
  int last_idx, last_cnt, lat, stab_bad, timeout, done_gap, busy_at_done;

  always #5 clk = ~clk;

  ntt_engine u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .inverse(inverse),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .busy(a_busy), .done(a_done)
  );

  ntt_engine #(.LOG_N(3), .W(5), .Q(17), .OMEGA(2), .OMEGA_INV(9), .N_INV(15)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .inverse(inverse),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data[4:0]),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy), .done(b_done)
  );

  // Direct O(N^2) transform of vec: X[k] = sum_j vec[j]*w^(jk) mod q (times ninv if inverse)
  function automatic int ref_elem(int n, int q, int w, int ninv, int inv, int k);
    longint acc, p;
    acc = 0;
    for (int j = 0; j < n; j++) begin
      p = 1;
      for (int e = 0; e < (j * k) % n; e++) p = (p * w) % q;
      acc = (acc + vec[j] * p) % q;
    end
    if (inv != 0) acc = (acc * ninv) % q;
    return int'(acc);
  endfunction

  task automatic run_job(input int sel, input int inv, input int n, input int stall,
                         input int chain, input int chain_inv, input int skip_start);
    int k, o, cyc, lasthk, od, pdata;
    logic ir, ov, ol, dn, bz, r, pst, plast;
    k = 0; o = 0; cyc = 0; lasthk = 0; pst = 0; pdata = 0; plast = 0;
    last_idx = -1; last_cnt = 0; lat = -1; stab_bad = 0; timeout = 0;
    done_gap = -1; busy_at_done = -1;
    if (skip_start == 0) begin
      @(negedge clk);
      inverse = inv[0];
      if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    end
    while (lat < 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start_a = 1'b0; start_b = 1'b0;
      ir = sel ? b_in_ready  : a_in_ready;
      ov = sel ? b_out_valid : a_out_valid;
      ol = sel ? b_out_last  : a_out_last;
      dn = sel ? b_done      : a_done;
      bz = sel ? b_busy      : a_busy;
      od = sel ? int'(b_out_data) : int'(a_out_data);
      if (ir && k < n) begin
        in_valid = (stall != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data  = 7'(vec[k]);
        if (in_valid) k++;
      end else in_valid = 1'b0;
      r = (stall != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      out_ready = r;
      if (pst && ov && (od != pdata || ol != plast)) stab_bad++;
      if (ov && r && o < 16) begin
        res[o] = od;
        if (ol) begin last_cnt++; last_idx = o; end
        o++;
        lasthk = cyc;
      end
      pst = ov && !r; pdata = od; plast = ol;
      if (dn) begin
        lat = cyc - 1;
        done_gap = cyc - lasthk;
        busy_at_done = int'(bz);
        if (chain != 0) begin
          inverse = chain_inv[0];
          if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        end
      end
    end
    if (lat < 0) timeout = 1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nc++;
    if ({a_in_ready, a_out_valid, a_out_last, a_busy, a_done, a_out_data} !== 12'd0) begin
      nf++; $display("FAIL reset_a outputs got %b exp 0",
                     {a_in_ready, a_out_valid, a_out_last, a_busy, a_done, a_out_data});
    end
    nc++;
    if ({b_in_ready, b_out_valid, b_out_last, b_busy, b_done, b_out_data} !== 10'd0) begin
      nf++; $display("FAIL reset_b outputs got %b exp 0",
                     {b_in_ready, b_out_valid, b_out_last, b_busy, b_done, b_out_data});
    end
    rst_n = 1'b1;
    @(negedge clk);
    nc++;
    if (a_busy !== 1'b0 || a_in_ready !== 1'b0) begin
      nf++; $display("FAIL idle_after_reset busy=%b in_ready=%b exp 0 0", a_busy, a_in_ready);
    end
  endtask

  task automatic test_impulse();
    for (int i = 0; i < 16; i++) vec[i] = (i == 0) ? 1 : 0;
    run_job(0, 0, 16, 0, 0, 0, 0);
    nc++; if (timeout !== 0) begin nf++; $display("FAIL impulse_timeout got %0d exp 0", timeout); end
    for (int i = 0; i < 16; i++) begin
      nc++; if (res[i] !== 1) begin nf++; $display("FAIL impulse[%0d] got %0d exp 1", i, res[i]); end
    end
    nc++;
    if (last_cnt !== 1 || last_idx !== 15) begin
      nf++; $display("FAIL impulse_last count=%0d idx=%0d exp 1 15", last_cnt, last_idx);
    end
    nc++; if (done_gap !== 1) begin nf++; $display("FAIL impulse_done_gap got %0d exp 1", done_gap); end
    nc++; if (busy_at_done !== 0) begin nf++; $display("FAIL busy_at_done got %0d exp 0", busy_at_done); end
    nc++; if (lat !== 72) begin nf++; $display("FAIL fwd_latency got %0d exp 72", lat); end
    @(negedge clk);
    nc++; if (a_done !== 1'b0) begin nf++; $display("FAIL done_pulse_width got %b exp 0", a_done); end
  endtask

  task automatic test_constant();
    for (int i = 0; i < 16; i++) vec[i] = 1;
    run_job(0, 0, 16, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      nc++;
      if (res[i] !== ((i == 0) ? 16 : 0)) begin
        nf++; $display("FAIL constant[%0d] got %0d exp %0d", i, res[i], (i == 0) ? 16 : 0);
      end
    end
  endtask

  task automatic test_ramp();
    int e;
    for (int i = 0; i < 16; i++) vec[i] = i + 1;
    run_job(0, 0, 16, 0, 0, 0, 0);
    nc++; if (res[0] !== 39) begin nf++; $display("FAIL ramp[0] got %0d exp 39", res[0]); end
    for (int i = 1; i < 16; i++) begin
      e = ref_elem(16, 97, 27, 91, 0, i);
      nc++; if (res[i] !== e) begin nf++; $display("FAIL ramp[%0d] got %0d exp %0d", i, res[i], e); end
    end
    for (int i = 0; i < 16; i++) begin ramp_out[i] = res[i]; vec[i] = res[i]; end
    run_job(0, 1, 16, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      nc++; if (res[i] !== i + 1) begin nf++; $display("FAIL ramp_roundtrip[%0d] got %0d exp %0d", i, res[i], i + 1); end
    end
    nc++; if (lat !== 88) begin nf++; $display("FAIL inv_latency got %0d exp 88", lat); end
  endtask

  task automatic test_inv_impulse();
    for (int i = 0; i < 16; i++) vec[i] = (i == 0) ? 16 : 0;
    run_job(0, 1, 16, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      nc++; if (res[i] !== 1) begin nf++; $display("FAIL inv_impulse[%0d] got %0d exp 1", i, res[i]); end
    end
  endtask

  task automatic test_stalls();
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 16; i++) vec[i] = i + 1;
      run_job(0, 0, 16, 1, 0, 0, 0);
      nc++; if (timeout !== 0) begin nf++; $display("FAIL stall_timeout got %0d exp 0", timeout); end
      for (int i = 0; i < 16; i++) begin
        nc++; if (res[i] !== ramp_out[i]) begin nf++; $display("FAIL stall_ramp[%0d] got %0d exp %0d", i, res[i], ramp_out[i]); end
      end
      nc++; if (stab_bad !== 0) begin nf++; $display("FAIL stall_stable changes=%0d exp 0", stab_bad); end
      nc++; if (last_idx !== 15) begin nf++; $display("FAIL stall_last idx=%0d exp 15", last_idx); end
    end
  endtask

  task automatic test_reset_mid_comp();
    int k, cyc;
    for (int i = 0; i < 16; i++) vec[i] = (i == 0) ? 1 : 0;
    @(negedge clk); inverse = 1'b0; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    k = 0; cyc = 0;
    while (k < 16 && cyc < 200) begin
      if (a_in_ready) begin in_valid = 1'b1; in_data = 7'(vec[k]); k++; end
      else in_valid = 1'b0;
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    nc++; if (a_busy !== 1'b1) begin nf++; $display("FAIL mid_comp_busy got %b exp 1", a_busy); end
    #2 rst_n = 1'b0;
    #1;
    nc++;
    if ({a_in_ready, a_out_valid, a_out_last, a_busy, a_done, a_out_data} !== 12'd0) begin
      nf++; $display("FAIL async_reset outputs got %b exp 0",
                     {a_in_ready, a_out_valid, a_out_last, a_busy, a_done, a_out_data});
    end
    @(negedge clk); rst_n = 1'b1;
    run_job(0, 0, 16, 0, 0, 0, 0);
    k = 0;
    for (int i = 0; i < 16; i++) if (res[i] !== 1) k++;
    nc++; if (k !== 0 || timeout !== 0) begin nf++; $display("FAIL post_reset_impulse bad=%0d timeout=%0d exp 0 0", k, timeout); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) vec[i] = 1;
    run_job(0, 0, 16, 0, 1, 0, 0);
    nc++; if (res[0] !== 16) begin nf++; $display("FAIL b2b_first[0] got %0d exp 16", res[0]); end
    for (int i = 0; i < 16; i++) vec[i] = (i == 0) ? 1 : 0;
    run_job(0, 0, 16, 0, 0, 0, 1);
    nc++; if (timeout !== 0) begin nf++; $display("FAIL b2b_timeout got %0d exp 0", timeout); end
    for (int i = 0; i < 16; i++) begin
      nc++; if (res[i] !== 1) begin nf++; $display("FAIL b2b_second[%0d] got %0d exp 1", i, res[i]); end
    end
  endtask

  task automatic test_sweep();
    int e;
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < 8; j++) vec[j] = int'($urandom_range(0, 16));
      run_job(1, 0, 8, v % 2, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
        e = ref_elem(8, 17, 2, 15, 0, k);
        nc++; if (res[k] !== e) begin nf++; $display("FAIL sweep_fwd v%0d[%0d] got %0d exp %0d", v, k, res[k], e); end
      end
      run_job(1, 1, 8, v % 2, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
        e = ref_elem(8, 17, 9, 15, 1, k);
        nc++; if (res[k] !== e) begin nf++; $display("FAIL sweep_inv v%0d[%0d] got %0d exp %0d", v, k, res[k], e); end
      end
      nc++; if (last_idx !== 7) begin nf++; $display("FAIL sweep_last idx=%0d exp 7", last_idx); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; inverse = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_impulse();
    test_constant();
    test_ramp();
    test_inv_impulse();
    test_stalls();
    test_reset_mid_comp();
    test_back_to_back();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule
